sqrt_request_scheduler: RTL and testbench

- Shares one iterative square-root engine (the odd-increment path_control/path_data pair) among several requesters.
- Round-robin arbitration picks one requester.
- Latches that requester's operand, issues a one-cycle start to the engine and waits for engine done, with a timeout guard.
- Returns the result to the granted requester with a one-cycle acknowledge.
- Sits between input sources (switch banks, test sequencers) and the engine; the result register also feeds the display digits.

---
 rtl/sqrt_request_scheduler.sv | 135 +++++++++++++
 tb/tb_sqrt_request_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_request_scheduler.sv
// ============================================================================
//  Module   : sqrt_request_scheduler
//  Purpose  : Round-robin scheduler sharing one iterative square-root engine
//             among several requesters, with a timeout guard on engine done.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sqrt_request_scheduler #(
  parameter int REQUESTERS    = 4,
  parameter int OPERAND_WIDTH = 8,
  parameter int RESULT_WIDTH  = 4,
  parameter int TIMEOUT       = 63
) (
  input  logic                                clock,
  input  logic                                clear,
  input  logic [REQUESTERS-1:0]               request,
  input  logic [REQUESTERS*OPERAND_WIDTH-1:0] operand,
  output logic [REQUESTERS-1:0]               acknowledge,
  output logic [RESULT_WIDTH-1:0]             result,
  output logic                                error,
  output logic                                busy,
  output logic                                engine_start,
  output logic [OPERAND_WIDTH-1:0]            engine_operand,
  input  logic                                engine_done,
  input  logic [RESULT_WIDTH-1:0]             engine_result
);

  localparam int c_PTR_WIDTH = $clog2(REQUESTERS);
  localparam int c_CNT_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [c_PTR_WIDTH-1:0] c_PTR_INIT = c_PTR_WIDTH'(REQUESTERS - 1);
  localparam logic [c_CNT_WIDTH-1:0] c_CNT_LAST = c_CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [REQUESTERS-1:0]  c_ACK_ONE  = REQUESTERS'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t                   r_state;
  logic [c_PTR_WIDTH-1:0]   r_pointer;
  logic [c_PTR_WIDTH-1:0]   r_grant;
  logic [c_CNT_WIDTH-1:0]   r_count;

  logic [OPERAND_WIDTH-1:0] w_operands [REQUESTERS];
  logic [c_PTR_WIDTH:0]     w_sum;
  logic [c_PTR_WIDTH-1:0]   w_idx;
  logic [c_PTR_WIDTH-1:0]   w_winner;
  logic                     w_any;

  for (genvar i = 0; i < REQUESTERS; i++) begin : g_operand
    assign w_operands[i] = operand[i*OPERAND_WIDTH +: OPERAND_WIDTH];
  end

  // Scan from the farthest offset down so the nearest set bit after the
  // pointer is the last one written and therefore wins.
  always_comb begin
    w_sum    = '0;
    w_idx    = '0;
    w_winner = r_pointer;
    w_any    = 1'b0;
    for (int off = REQUESTERS; off >= 1; off--) begin
      w_sum = {1'b0, r_pointer} + (c_PTR_WIDTH + 1)'(off);
      if (w_sum >= (c_PTR_WIDTH + 1)'(REQUESTERS)) begin
        w_sum = w_sum - (c_PTR_WIDTH + 1)'(REQUESTERS);
      end
      w_idx = w_sum[c_PTR_WIDTH-1:0];
      if (request[w_idx]) begin
        w_winner = w_idx;
        w_any    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state        <= S_IDLE;
      r_pointer      <= c_PTR_INIT;
      r_grant        <= '0;
      r_count        <= '0;
      acknowledge    <= '0;
      result         <= '0;
      error          <= 1'b0;
      busy           <= 1'b0;
      engine_start   <= 1'b0;
      engine_operand <= '0;
    end else begin
      acknowledge  <= '0;
      engine_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            engine_operand <= w_operands[w_winner];
            r_grant        <= w_winner;
            engine_start   <= 1'b1;
            busy           <= 1'b1;
            r_state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_count <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // done on the expiry edge still counts as a success
          if (engine_done) begin
            result      <= engine_result;
            error       <= 1'b0;
            acknowledge <= c_ACK_ONE << r_grant;
            r_state     <= S_RESPOND;
          end else if (r_count == c_CNT_LAST) begin
            result      <= '0;
            error       <= 1'b1;
            acknowledge <= c_ACK_ONE << r_grant;
            r_state     <= S_RESPOND;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        S_RESPOND: begin
          r_pointer <= r_grant;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sqrt_request_scheduler.sv
// ============================================================================
//  Module   : tb_sqrt_request_scheduler
//  Purpose  : Scoreboard bench for sqrt_request_scheduler with a 5-cycle engine.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sqrt_request_scheduler;

  localparam int R  = 4;
  localparam int OW = 8;
  localparam int RW = 4;
  localparam int TO = 63;

  logic              clock = 1'b0;
  logic              clear = 1'b1;
  logic [R-1:0]      request = '0;
  logic [R*OW-1:0]   operand = '0;
  logic [R-1:0]      acknowledge;
  logic [RW-1:0]     result;
  logic              error;
  logic              busy;
  logic              engine_start;
  logic [OW-1:0]     engine_operand;
  logic              engine_done = 1'b0;
  logic [RW-1:0]     engine_result = '0;

  always #5 clock = ~clock;

  sqrt_request_scheduler #(
    .REQUESTERS(R), .OPERAND_WIDTH(OW), .RESULT_WIDTH(RW), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .clear(clear), .request(request), .operand(operand),
    .acknowledge(acknowledge), .result(result), .error(error), .busy(busy),
    .engine_start(engine_start), .engine_operand(engine_operand),
    .engine_done(engine_done), .engine_result(engine_result)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Engine model: done pulses in the 5th cycle after start is sampled.
  logic       hang = 1'b0;
  int         eng_cnt = 0;
  logic       eng_run = 1'b0;
  logic [OW-1:0] eng_op = '0;

  always @(posedge clock) begin
    engine_done <= 1'b0;
    if (engine_start) begin
      eng_op  <= engine_operand;
      eng_cnt <= 4;
      eng_run <= 1'b1;
    end else if (eng_run) begin
      if (eng_cnt == 1) begin
        eng_run <= 1'b0;
        if (!hang) begin
          engine_done   <= 1'b1;
          engine_result <= RW'(isqrt(int'(eng_op)));
        end
      end
      eng_cnt <= eng_cnt - 1;
    end
  end

  typedef struct { int idx; int res; int err; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  bit   prev_ack = 1'b0;

  task automatic expect_ack(input int idx, input int res, input int err);
    exp_t e;
    e.idx = idx; e.res = res; e.err = err;
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (acknowledge != '0) begin
      check("ack_single_cycle", 32'(prev_ack), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'(acknowledge), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_vector", 32'(acknowledge), 32'(1 << mon_e.idx));
        check("result", 32'(result), 32'(mon_e.res));
        check("error", 32'(error), 32'(mon_e.err));
      end
    end
    prev_ack = (acknowledge != '0);
  end

  task automatic set_op(input int idx, input int val);
    operand[idx*OW +: OW] = OW'(val);
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear   = 1'b1;
    request = '0;
    repeat (2) @(negedge clock);
    check("rst_ack", 32'(acknowledge), 0);
    check("rst_result", 32'(result), 0);
    check("rst_error", 32'(error), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_engine_start", 32'(engine_start), 0);
    check("rst_engine_operand", 32'(engine_operand), 0);
    clear = 1'b0;
  endtask

  // Raise mask during an IDLE cycle and collect n acknowledges.
  task automatic run(input logic [R-1:0] mask, input int n_acks, input bit drop_each,
                     output int ack_lat, output int start_lat);
    int seen = 0;
    int cyc  = 0;
    ack_lat   = -1;
    start_lat = -1;
    @(negedge clock);
    request = request | mask;
    while (seen < n_acks && cyc < 400) begin
      @(negedge clock);
      cyc++;
      if (engine_start && start_lat < 0) start_lat = cyc;
      if (acknowledge != '0) begin
        seen++;
        if (ack_lat < 0) ack_lat = cyc;
        if (drop_each) request = request & ~acknowledge;
        if (seen == n_acks) request = request & ~mask;
      end
    end
    request = request & ~mask;
    if (seen < n_acks) check("ack_wait_bound", 32'(seen), 32'(n_acks));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, slat;
    do_reset();

    // Basic: operand 49 on requester 0
    set_op(0, 49);
    expect_ack(0, 7, 0);
    run(4'b0001, 1, 1'b1, lat, slat);
    check("basic_start_latency", 32'(slat), 1);
    check("basic_ack_latency", 32'(lat), 7);
    @(negedge clock);
    check("basic_busy_after", 32'(busy), 0);

    // Boundaries
    set_op(1, 0);   expect_ack(1, 0, 0);  run(4'b0010, 1, 1'b1, lat, slat);
    set_op(2, 255); expect_ack(2, 15, 0); run(4'b0100, 1, 1'b1, lat, slat);
    set_op(3, 1);   expect_ack(3, 1, 0);  run(4'b1000, 1, 1'b1, lat, slat);
    set_op(0, 48);  expect_ack(0, 6, 0);  run(4'b0001, 1, 1'b1, lat, slat);

    // Simultaneous from reset
    do_reset();
    set_op(0, 16); set_op(2, 81);
    expect_ack(0, 4, 0);
    expect_ack(2, 9, 0);
    run(4'b0101, 2, 1'b1, lat, slat);
    check("simul_first_latency", 32'(lat), 7);

    // Fairness with all requests held
    do_reset();
    set_op(0, 4); set_op(1, 9); set_op(2, 25); set_op(3, 36);
    expect_ack(0, 2, 0); expect_ack(1, 3, 0); expect_ack(2, 5, 0);
    expect_ack(3, 6, 0); expect_ack(0, 2, 0); expect_ack(1, 3, 0);
    run(4'b1111, 6, 1'b0, lat, slat);

    // Timeout, then a normal request
    hang = 1'b1;
    set_op(3, 200);
    expect_ack(3, 0, 1);
    run(4'b1000, 1, 1'b1, lat, slat);
    check("timeout_ack_latency", 32'(lat), 2 + TO);
    hang = 1'b0;
    set_op(1, 100);
    expect_ack(1, 10, 0);
    run(4'b0010, 1, 1'b1, lat, slat);

    // Reset in the 3rd WAIT cycle of an operation on requester 2
    @(negedge clock);
    set_op(2, 200);
    request = 4'b0100;
    repeat (4) @(negedge clock);
    check("midop_busy_before", 32'(busy), 1);
    clear   = 1'b1;
    request = '0;
    @(negedge clock);
    check("midop_busy", 32'(busy), 0);
    check("midop_result", 32'(result), 0);
    check("midop_ack", 32'(acknowledge), 0);
    clear = 1'b0;
    repeat (6) @(negedge clock);
    check("late_done_ignored_busy", 32'(busy), 0);
    set_op(1, 9); set_op(2, 64);
    expect_ack(1, 3, 0);
    expect_ack(2, 8, 0);
    run(4'b0110, 2, 1'b1, lat, slat);

    repeat (10) @(negedge clock);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
